// File: rtl/medac_cnt_readout.sv
`default_nettype none
// ============================================================================
// Module      : medac_cnt_readout
// Description : Captures the MEDAC result counters on a read request and
//               shifts them off-chip as a framed serial word:
//                 {HDR[7:0], snap_err, snap_cyc, CHK[7:0]}  (MSB first)
//               CHK is HDR XOR every byte of both captured counters.
//               Each bit is held for BIT_DIV clocks; at least GAP_CYC idle
//               clocks separate consecutive frames.
// Ports       : clk, rst_n (async, active-low)
//               error_origin_cnt, cycle_cnt : counter inputs (clk domain)
//               rd_req   : frame request, level-sampled
//               busy     : frame or inter-frame gap in progress
//               sdo      : serial data, idles high
//               sframe   : high for exactly the data bits of a frame
//               done     : one-cycle end-of-frame pulse
//               overrun  : sticky, request seen while busy
//               snap_err, snap_cyc : last captured counter values
// Revision    : 1.0 - initial release
// ============================================================================
module medac_cnt_readout #(
  parameter int         CNT_W   = 32,
  parameter logic [7:0] HDR     = 8'hA5,
  parameter int         BIT_DIV = 4,
  parameter int         GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] error_origin_cnt,
  input  logic [CNT_W-1:0] cycle_cnt,
  input  logic             rd_req,
  output logic             busy,
  output logic             sdo,
  output logic             sframe,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] snap_err,
  output logic [CNT_W-1:0] snap_cyc
);

  localparam int c_FRAME_L = 16 + 2 * CNT_W;
  localparam int c_NBYTES  = CNT_W / 8;
  localparam int c_BC_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int c_GC_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int c_BI_W    = $clog2(c_FRAME_L);

  localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(BIT_DIV - 1);
  localparam logic [c_GC_W-1:0] c_GC_LAST = c_GC_W'(GAP_CYC - 1);
  localparam logic [c_BI_W-1:0] c_BI_TOP  = c_BI_W'(c_FRAME_L - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 state_q,    state_d;
  logic [c_FRAME_L-1:0]   shreg_q,    shreg_d;
  logic [c_BC_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [c_BI_W-1:0]      bit_idx_q,  bit_idx_d;
  logic [c_GC_W-1:0]      gap_cnt_q,  gap_cnt_d;
  logic                   busy_q,     busy_d;
  logic                   sdo_q,      sdo_d;
  logic                   sframe_q,   sframe_d;
  logic                   done_q,     done_d;
  logic                   overrun_q,  overrun_d;
  logic [CNT_W-1:0]       snap_err_q, snap_err_d;
  logic [CNT_W-1:0]       snap_cyc_q, snap_cyc_d;

  logic [7:0]             w_chk;
  logic [c_FRAME_L-1:0]   w_frame;

  // Checksum is formed from the live inputs; it is only ever loaded on the
  // capture edge, where those inputs equal the values going into snap_*.
  always_comb begin
    w_chk = HDR;
    for (int i = 0; i < c_NBYTES; i++) begin
      w_chk = w_chk ^ error_origin_cnt[8*i +: 8] ^ cycle_cnt[8*i +: 8];
    end
  end

  assign w_frame = {HDR, error_origin_cnt, cycle_cnt, w_chk};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    gap_cnt_d  = gap_cnt_q;
    busy_d     = busy_q;
    sdo_d      = sdo_q;
    sframe_d   = sframe_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    snap_err_d = snap_err_q;
    snap_cyc_d = snap_cyc_q;

    case (state_q)
      IDLE: begin
        if (rd_req) begin
          snap_err_d = error_origin_cnt;
          snap_cyc_d = cycle_cnt;
          shreg_d    = w_frame;
          sdo_d      = w_frame[c_FRAME_L-1];
          sframe_d   = 1'b1;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          bit_idx_d  = c_BI_TOP;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (rd_req) overrun_d = 1'b1;
        if (bit_cnt_q == c_BC_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == '0) begin
            sframe_d  = 1'b0;
            sdo_d     = 1'b1;
            done_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            // sdo mirrors the shift register MSB one bit ahead of the shift.
            bit_idx_d = bit_idx_q - 1'b1;
            sdo_d     = shreg_q[c_FRAME_L-2];
            shreg_d   = shreg_q << 1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (rd_req) overrun_d = 1'b1;
        if (gap_cnt_q == c_GC_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        sframe_d = 1'b0;
        sdo_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      gap_cnt_q  <= '0;
      busy_q     <= 1'b0;
      sdo_q      <= 1'b1;
      sframe_q   <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      snap_err_q <= '0;
      snap_cyc_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      busy_q     <= busy_d;
      sdo_q      <= sdo_d;
      sframe_q   <= sframe_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      snap_err_q <= snap_err_d;
      snap_cyc_q <= snap_cyc_d;
    end
  end

  assign busy     = busy_q;
  assign sdo      = sdo_q;
  assign sframe   = sframe_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign snap_err = snap_err_q;
  assign snap_cyc = snap_cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_medac_cnt_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_medac_cnt_readout
// Description : Directed bench for medac_cnt_readout. Expected frames are
//               queued when a request is issued and compared by a serial
//               decoder when each frame ends.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_medac_cnt_readout;

  localparam int         CNT_W   = 32;
  localparam logic [7:0] HDR     = 8'hA5;
  localparam int         BIT_DIV = 4;
  localparam int         GAP_CYC = 2;
  localparam int         L       = 16 + 2 * CNT_W;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic [CNT_W-1:0] err_in = '0;
  logic [CNT_W-1:0] cyc_in = '0;
  logic             rd_req = 1'b0;
  logic             busy, sdo, sframe, done, overrun;
  logic [CNT_W-1:0] snap_err, snap_cyc;

  int checks = 0;
  int errors = 0;

  logic [L-1:0] sb[$];

  logic         prev_sf  = 1'b0;
  int           fcnt     = 0;
  int           gcnt     = 0;
  int           last_gap = -1;
  logic [L-1:0] fbits    = '0;

  medac_cnt_readout #(
    .CNT_W  (CNT_W),
    .HDR    (HDR),
    .BIT_DIV(BIT_DIV),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .error_origin_cnt(err_in),
    .cycle_cnt       (cyc_in),
    .rd_req          (rd_req),
    .busy            (busy),
    .sdo             (sdo),
    .sframe          (sframe),
    .done            (done),
    .overrun         (overrun),
    .snap_err        (snap_err),
    .snap_cyc        (snap_cyc)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [L-1:0] model_frame(input logic [CNT_W-1:0] e, input logic [CNT_W-1:0] c);
    logic [7:0] k;
    k = HDR;
    for (int i = 0; i < CNT_W / 8; i++) k = k ^ e[8*i +: 8] ^ c[8*i +: 8];
    return {HDR, e, c, k};
  endfunction

  // Serial decoder: one sample per bit (first cycle of the bit), frame
  // length, done alignment, idle level and inter-frame gap measurement.
  always @(negedge clk) begin
    if (sframe) begin
      if (!prev_sf) begin
        last_gap = gcnt;
        fcnt     = 0;
        fbits    = '0;
      end
      if (fcnt % BIT_DIV == 0) fbits = {fbits[L-2:0], sdo};
      fcnt++;
      chk("done_in_frame", L'(done), L'(0));
    end else begin
      if (prev_sf) begin
        if (rst_n) begin
          chk("frame_len", L'(fcnt), L'(L * BIT_DIV));
          chk("done_at_end", L'(done), L'(1));
          chk("sb_nonempty", L'(sb.size() > 0), L'(1));
          if (sb.size() > 0) chk("frame", fbits, sb.pop_front());
        end else begin
          chk("abort_no_done", L'(done), L'(0));
          if (sb.size() > 0) void'(sb.pop_front());
        end
        gcnt = 1;
      end else begin
        gcnt++;
        chk("done_idle", L'(done), L'(0));
      end
      chk("sdo_idle", L'(sdo), L'(1));
    end
    prev_sf = sframe;
  end

  task automatic pulse_req(input logic [CNT_W-1:0] e, input logic [CNT_W-1:0] c,
                           input logic [L-1:0] exp_frame);
    err_in = e;
    cyc_in = c;
    rd_req = 1'b1;
    sb.push_back(exp_frame);
    @(posedge clk);
    #1 rd_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < bound && !seen; n++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    chk(tag, L'(seen), L'(1));
  endtask

  task automatic wait_idle(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < bound && !seen; n++) begin
      @(negedge clk);
      seen = (busy === 1'b0);
    end
    chk(tag, L'(seen), L'(1));
  endtask

  initial begin
    // Reset values, applied asynchronously before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",    L'(busy),     L'(0));
    chk("rst_sdo",     L'(sdo),      L'(1));
    chk("rst_sframe",  L'(sframe),   L'(0));
    chk("rst_done",    L'(done),     L'(0));
    chk("rst_overrun", L'(overrun),  L'(0));
    chk("rst_snap_err", L'(snap_err), L'(0));
    chk("rst_snap_cyc", L'(snap_cyc), L'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_sdo",     L'(sdo),      L'(1));
    chk("idle_sframe",  L'(sframe),   L'(0));
    chk("idle_busy",    L'(busy),     L'(0));
    chk("idle_overrun", L'(overrun),  L'(0));
    chk("idle_snap_err", L'(snap_err), L'(0));

    // Basic frame with a hand-computed checksum.
    pulse_req(32'h0000_0003, 32'h0000_0010, 80'hA5_00000003_00000010_B6);
    wait_done("t2_done_timeout", 400);
    chk("t2_snap_err", L'(snap_err), L'(32'h3));
    chk("t2_snap_cyc", L'(snap_cyc), L'(32'h10));
    chk("t2_busy_gap", L'(busy),     L'(1));
    chk("t2_overrun",  L'(overrun),  L'(0));
    wait_idle("t2_idle_timeout", 50);

    // All-ones counter; inputs scrambled while shifting.
    pulse_req(32'hFFFF_FFFF, 32'h1234_5678, model_frame(32'hFFFF_FFFF, 32'h1234_5678));
    repeat (300) begin
      @(negedge clk);
      err_in = $urandom;
      cyc_in = $urandom;
    end
    wait_done("t3_done_timeout", 100);
    chk("t3_snap_err", L'(snap_err), L'(32'hFFFF_FFFF));
    chk("t3_snap_cyc", L'(snap_cyc), L'(32'h1234_5678));
    chk("t3_overrun",  L'(overrun),  L'(0));
    wait_idle("t3_idle_timeout", 50);

    // Requests during SHIFT and GAP are ignored but flag overrun.
    pulse_req(32'h0BAD_F00D, 32'hCAFE_0001, model_frame(32'h0BAD_F00D, 32'hCAFE_0001));
    repeat (100) @(negedge clk);
    rd_req = 1'b1;
    @(posedge clk);
    #1 rd_req = 1'b0;
    @(negedge clk);
    chk("t4_overrun_shift", L'(overrun), L'(1));
    wait_done("t4_done_timeout", 400);
    rd_req = 1'b1;
    @(posedge clk);
    #1 rd_req = 1'b0;
    @(negedge clk);
    chk("t4_busy_in_gap", L'(busy),    L'(1));
    chk("t4_overrun_gap", L'(overrun), L'(1));
    chk("t4_snap_err",    L'(snap_err), L'(32'h0BAD_F00D));
    wait_idle("t4_idle_timeout", 50);
    pulse_req(32'h0, 32'h0, model_frame(32'h0, 32'h0));
    wait_done("t4b_done_timeout", 400);
    chk("t4b_snap_err", L'(snap_err), L'(0));
    chk("t4b_overrun",  L'(overrun),  L'(1));
    wait_idle("t4b_idle_timeout", 50);

    // Held request: back-to-back frames at accept edges 1, 324 and 647.
    err_in = 32'h0102_0304;
    cyc_in = 32'hA0B0_C0D0;
    repeat (3) sb.push_back(model_frame(32'h0102_0304, 32'hA0B0_C0D0));
    rd_req = 1'b1;
    repeat (800) @(posedge clk);
    #1 rd_req = 1'b0;
    wait_done("t5_done_timeout", 400);
    chk("t5_gap_len",  L'(last_gap), L'(GAP_CYC + 1));
    chk("t5_overrun",  L'(overrun),  L'(1));
    wait_idle("t5_idle_timeout", 50);
    chk("t5_sb_empty", L'(sb.size()), L'(0));

    // Reset in the middle of a frame, then a fresh frame.
    pulse_req(32'h55AA_55AA, 32'h8000_0001, model_frame(32'h55AA_55AA, 32'h8000_0001));
    repeat (150) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sframe",  L'(sframe),  L'(0));
    chk("t6_busy",    L'(busy),    L'(0));
    chk("t6_sdo",     L'(sdo),     L'(1));
    chk("t6_done",    L'(done),    L'(0));
    chk("t6_overrun", L'(overrun), L'(0));
    chk("t6_snap",    L'(snap_err), L'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_req(32'h1357_9BDF, 32'h2468_ACE0, model_frame(32'h1357_9BDF, 32'h2468_ACE0));
    wait_done("t6_done_timeout", 400);
    chk("t6_snap_err", L'(snap_err), L'(32'h1357_9BDF));
    chk("t6_snap_cyc", L'(snap_cyc), L'(32'h2468_ACE0));
    wait_idle("t6_idle_timeout", 50);
    chk("t6_sb_empty", L'(sb.size()), L'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
